// File: rtl/riscv_mc_controller.sv
// Multicycle RV32I main controller: steps each instruction through fetch, decode,
// execute, memory and writeback, stalling on mem_ready in the memory-facing states.
module riscv_mc_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [3:0] flags,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_control,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_JALR1    = 4'd11;
  localparam logic [3:0] S_JALR2    = 4'd12;
  localparam logic [3:0] S_LUI      = 4'd13;
  localparam logic [3:0] S_AUIPC    = 4'd14;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b1101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] A_PC    = 2'b00;
  localparam logic [1:0] A_OLDPC = 2'b01;
  localparam logic [1:0] A_RS1   = 2'b10;
  localparam logic [1:0] A_ZERO  = 2'b11;

  localparam logic [1:0] B_RS2  = 2'b00;
  localparam logic [1:0] B_IMM  = 2'b01;
  localparam logic [1:0] B_FOUR = 2'b10;

  logic [3:0] state_q, state_d;
  logic [3:0] dec_next;
  logic       dec_illegal;
  logic [3:0] arith_alu;
  logic [3:0] br_alu;
  logic       br_taken;
  logic       zero_flag;
  logic       unused_flags;
  logic       pc_write_raw, ir_write_raw, reg_write_raw, mem_write_raw, illegal_raw;

  assign zero_flag    = flags[2];
  assign unused_flags = ^{flags[3], flags[1:0]};

  // Illegal is not a state: DECODE flags it and returns straight to FETCH.
  always_comb begin
    dec_next    = S_FETCH;
    dec_illegal = 1'b0;
    case (op)
      OP_LOAD, OP_STORE: dec_next = S_MEMADR;
      OP_R:              dec_next = S_EXECR;
      OP_I:              dec_next = S_EXECI;
      OP_BRANCH: begin
        if (funct3 == 3'b010 || funct3 == 3'b011) dec_illegal = 1'b1;
        else                                      dec_next    = S_BRANCH;
      end
      OP_JAL:            dec_next = S_JAL;
      OP_JALR: begin
        if (funct3 == 3'b000) dec_next    = S_JALR1;
        else                  dec_illegal = 1'b1;
      end
      OP_LUI:            dec_next = S_LUI;
      OP_AUIPC:          dec_next = S_AUIPC;
      default:           dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    arith_alu = ALU_ADD;
    case (funct3)
      3'b000: arith_alu = (state_q == S_EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001: arith_alu = ALU_SLL;
      3'b010: arith_alu = ALU_SLT;
      3'b011: arith_alu = ALU_SLTU;
      3'b100: arith_alu = ALU_XOR;
      3'b101: arith_alu = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110: arith_alu = ALU_OR;
      3'b111: arith_alu = ALU_AND;
    endcase
  end

  // Every branch compare leaves its answer in Z: SUB for equality, SLT/SLTU yield 0 when not less.
  always_comb begin
    br_alu   = ALU_ADD;
    br_taken = 1'b0;
    case (funct3)
      3'b000: begin br_alu = ALU_SUB;  br_taken = zero_flag;  end
      3'b001: begin br_alu = ALU_SUB;  br_taken = ~zero_flag; end
      3'b100: begin br_alu = ALU_SLT;  br_taken = ~zero_flag; end
      3'b101: begin br_alu = ALU_SLT;  br_taken = zero_flag;  end
      3'b110: begin br_alu = ALU_SLTU; br_taken = ~zero_flag; end
      3'b111: begin br_alu = ALU_SLTU; br_taken = zero_flag;  end
      default: begin br_alu = ALU_ADD; br_taken = 1'b0;       end
    endcase
  end

  always_comb begin
    state_d       = state_q;
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    mem_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    adr_src       = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = A_PC;
    alu_src_b     = B_RS2;
    alu_control   = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        alu_src_b    = B_FOUR;
        result_src   = RES_ALURES;
        pc_write_raw = mem_ready;
        ir_write_raw = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a   = A_OLDPC;
        alu_src_b   = B_IMM;
        illegal_raw = dec_illegal;
        state_d     = dec_next;
      end
      S_MEMADR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        state_d   = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src    = RES_DATA;
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a   = A_RS1;
        alu_control = arith_alu;
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a   = A_RS1;
        alu_src_b   = B_IMM;
        alu_control = arith_alu;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a    = A_RS1;
        alu_control  = br_alu;
        pc_write_raw = br_taken;
        state_d      = S_FETCH;
      end
      S_JAL: begin
        alu_src_a    = A_OLDPC;
        alu_src_b    = B_FOUR;
        pc_write_raw = 1'b1;
        state_d      = S_ALUWB;
      end
      S_JALR1: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        state_d   = S_JALR2;
      end
      S_JALR2: begin
        alu_src_a    = A_OLDPC;
        alu_src_b    = B_FOUR;
        pc_write_raw = 1'b1;
        state_d      = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a = A_ZERO;
        alu_src_b = B_IMM;
        state_d   = S_ALUWB;
      end
      S_AUIPC: begin
        alu_src_a = A_OLDPC;
        alu_src_b = B_IMM;
        state_d   = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Holding reset also masks every write strobe so an aborted access leaves no side effect.
  assign pc_write  = pc_write_raw  & rst;
  assign ir_write  = ir_write_raw  & rst;
  assign reg_write = reg_write_raw & rst;
  assign mem_write = mem_write_raw & rst;
  assign illegal   = illegal_raw   & rst;
  assign state     = state_q;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Bench for riscv_mc_controller: directed vector table, hand-written stall/reset/illegal
// sequences, and random instructions checked against an instruction-level trace model.
module tb_riscv_mc_controller;
  logic       clk, rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic [3:0] flags;
  logic       mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [3:0] alu_control;
  logic       illegal;
  logic [3:0] state;

  riscv_mc_controller dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .flags(flags), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .illegal(illegal), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, memw, irw, regw;
    logic [1:0] rs, sa, sb;
    logic [3:0] alu;
    logic       ill;
  } obs_t;

  typedef enum int {K_LOAD, K_STORE, K_R, K_I, K_BR, K_JAL, K_JALR, K_LUI, K_AUIPC, K_ILL} kind_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    int         len;
    logic [3:0] st3;
    logic [3:0] alu3;
    logic       pcw3;
    logic       ill2;
  } vec_t;

  int   n_pass = 0;
  int   n_total = 0;
  obs_t plan_q[$];
  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t observe();
    obs_t o;
    o = {state, pc_write, adr_src, mem_write, ir_write, reg_write,
         result_src, alu_src_a, alu_src_b, alu_control, illegal};
    return o;
  endfunction

  function automatic obs_t mk(input logic [3:0] st, input logic [1:0] sa,
                              input logic [1:0] sb, input logic [3:0] alu);
    obs_t o;
    o     = '0;
    o.st  = st;
    o.sa  = sa;
    o.sb  = sb;
    o.alu = alu;
    return o;
  endfunction

  function automatic kind_t classify(input logic [6:0] o, input logic [2:0] f3);
    case (o)
      7'h03: return K_LOAD;
      7'h23: return K_STORE;
      7'h33: return K_R;
      7'h13: return K_I;
      7'h63: return (f3 == 3'd2 || f3 == 3'd3) ? K_ILL : K_BR;
      7'h6f: return K_JAL;
      7'h67: return (f3 == 3'd0) ? K_JALR : K_ILL;
      7'h37: return K_LUI;
      7'h17: return K_AUIPC;
      default: return K_ILL;
    endcase
  endfunction

  // Mnemonic order by funct3: add sll slt sltu xor srl or and.
  function automatic logic [3:0] arith_code(input bit is_r, input logic [2:0] f3, input logic f7);
    logic [3:0] tab [8];
    tab = '{4'b0000, 4'b0110, 4'b0101, 4'b1101, 4'b0100, 4'b0111, 4'b0011, 4'b0010};
    if (f3 == 3'd0 && is_r && f7) return 4'b0001;
    if (f3 == 3'd5 && f7) return 4'b1111;
    return tab[f3];
  endfunction

  // Expected per-cycle trace of one instruction with memory always ready.
  function automatic void build_plan(input kind_t k, input logic [2:0] f3, input logic f7,
                                     input logic taken);
    obs_t o;
    obs_t wb;
    plan_q.delete();
    o = mk(4'd0, 2'b00, 2'b10, 4'b0000); o.rs = 2'b10; o.pcw = 1'b1; o.irw = 1'b1;
    plan_q.push_back(o);
    o = mk(4'd1, 2'b01, 2'b01, 4'b0000); o.ill = (k == K_ILL);
    plan_q.push_back(o);
    wb = mk(4'd8, 2'b00, 2'b00, 4'b0000); wb.regw = 1'b1;
    case (k)
      K_LOAD: begin
        plan_q.push_back(mk(4'd2, 2'b10, 2'b01, 4'b0000));
        o = mk(4'd3, 2'b00, 2'b00, 4'b0000); o.adr = 1'b1; plan_q.push_back(o);
        o = mk(4'd4, 2'b00, 2'b00, 4'b0000); o.rs = 2'b01; o.regw = 1'b1; plan_q.push_back(o);
      end
      K_STORE: begin
        plan_q.push_back(mk(4'd2, 2'b10, 2'b01, 4'b0000));
        o = mk(4'd5, 2'b00, 2'b00, 4'b0000); o.adr = 1'b1; o.memw = 1'b1; plan_q.push_back(o);
      end
      K_R: begin
        plan_q.push_back(mk(4'd6, 2'b10, 2'b00, arith_code(1'b1, f3, f7)));
        plan_q.push_back(wb);
      end
      K_I: begin
        plan_q.push_back(mk(4'd7, 2'b10, 2'b01, arith_code(1'b0, f3, f7)));
        plan_q.push_back(wb);
      end
      K_BR: begin
        o = mk(4'd9, 2'b10, 2'b00, (f3[2:1] == 2'b00) ? 4'b0001 :
                                   (f3[2:1] == 2'b10) ? 4'b0101 : 4'b1101);
        o.pcw = taken;
        plan_q.push_back(o);
      end
      K_JAL: begin
        o = mk(4'd10, 2'b01, 2'b10, 4'b0000); o.pcw = 1'b1; plan_q.push_back(o);
        plan_q.push_back(wb);
      end
      K_JALR: begin
        plan_q.push_back(mk(4'd11, 2'b10, 2'b01, 4'b0000));
        o = mk(4'd12, 2'b01, 2'b10, 4'b0000); o.pcw = 1'b1; plan_q.push_back(o);
        plan_q.push_back(wb);
      end
      K_LUI: begin
        plan_q.push_back(mk(4'd13, 2'b11, 2'b01, 4'b0000));
        plan_q.push_back(wb);
      end
      K_AUIPC: begin
        plan_q.push_back(mk(4'd14, 2'b01, 2'b01, 4'b0000));
        plan_q.push_back(wb);
      end
      default: ;
    endcase
  endfunction

  task automatic drive_check(input obs_t e, input logic mr, input string name);
    mem_ready = mr;
    @(negedge clk);
    check(name, 32'(observe()), 32'(e));
    tick();
  endtask

  task automatic run_plan(input int stall_max, input string tag);
    obs_t e, s;
    foreach (plan_q[i]) begin
      e = plan_q[i];
      if (e.st == 4'd0 || e.st == 4'd3 || e.st == 4'd5) begin
        s = e; s.pcw = 1'b0; s.irw = 1'b0;
        repeat ($urandom_range(0, stall_max))
          drive_check(s, 1'b0, $sformatf("%s_stall_st%0d", tag, e.st));
        drive_check(e, 1'b1, $sformatf("%s_st%0d", tag, e.st));
      end else begin
        drive_check(e, 1'($urandom_range(0, 1)), $sformatf("%s_st%0d", tag, e.st));
      end
    end
  endtask

  initial begin
    int cyc, fz, rz, irp;
    bit started;
    logic [3:0] st3, alu3;
    logic pcw3, ill2, rw4;
    logic [1:0] rs4;
    logic [3:0] jst [5];
    logic jpw [5];
    logic [6:0] ops [11];
    logic [31:0] a, b;
    logic z, taken;
    kind_t k;

    vecs[0]  = '{7'h33, 3'd0, 1'b1, 1'b0, 4, 4'd6,  4'b0001, 1'b0, 1'b0};
    vecs[1]  = '{7'h33, 3'd5, 1'b1, 1'b0, 4, 4'd6,  4'b1111, 1'b0, 1'b0};
    vecs[2]  = '{7'h33, 3'd0, 1'b0, 1'b0, 4, 4'd6,  4'b0000, 1'b0, 1'b0};
    vecs[3]  = '{7'h33, 3'd2, 1'b0, 1'b0, 4, 4'd6,  4'b0101, 1'b0, 1'b0};
    vecs[4]  = '{7'h13, 3'd0, 1'b1, 1'b0, 4, 4'd7,  4'b0000, 1'b0, 1'b0};
    vecs[5]  = '{7'h13, 3'd5, 1'b1, 1'b0, 4, 4'd7,  4'b1111, 1'b0, 1'b0};
    vecs[6]  = '{7'h13, 3'd3, 1'b0, 1'b0, 4, 4'd7,  4'b1101, 1'b0, 1'b0};
    vecs[7]  = '{7'h13, 3'd5, 1'b0, 1'b0, 4, 4'd7,  4'b0111, 1'b0, 1'b0};
    vecs[8]  = '{7'h63, 3'd0, 1'b0, 1'b1, 3, 4'd9,  4'b0001, 1'b1, 1'b0};
    vecs[9]  = '{7'h63, 3'd5, 1'b0, 1'b0, 3, 4'd9,  4'b0101, 1'b0, 1'b0};
    vecs[10] = '{7'h63, 3'd6, 1'b0, 1'b0, 3, 4'd9,  4'b1101, 1'b1, 1'b0};
    vecs[11] = '{7'h63, 3'd1, 1'b0, 1'b1, 3, 4'd9,  4'b0001, 1'b0, 1'b0};
    vecs[12] = '{7'h6f, 3'd0, 1'b0, 1'b0, 4, 4'd10, 4'b0000, 1'b1, 1'b0};
    vecs[13] = '{7'h37, 3'd0, 1'b0, 1'b0, 4, 4'd13, 4'b0000, 1'b0, 1'b0};
    vecs[14] = '{7'h03, 3'd2, 1'b0, 1'b0, 5, 4'd2,  4'b0000, 1'b0, 1'b0};
    vecs[15] = '{7'h23, 3'd2, 1'b0, 1'b0, 4, 4'd2,  4'b0000, 1'b0, 1'b0};
    vecs[16] = '{7'h67, 3'd0, 1'b0, 1'b0, 5, 4'd11, 4'b0000, 1'b0, 1'b0};
    vecs[17] = '{7'h7f, 3'd0, 1'b0, 1'b0, 2, 4'd0,  4'b0000, 1'b1, 1'b1};
    vecs[18] = '{7'h63, 3'd2, 1'b0, 1'b0, 2, 4'd0,  4'b0000, 1'b1, 1'b1};
    vecs[19] = '{7'h67, 3'd1, 1'b0, 1'b0, 2, 4'd0,  4'b0000, 1'b1, 1'b1};
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h7f, 7'h00};

    rst = 1'b0; op = 7'h00; funct3 = 3'd0; funct7b5 = 1'b0; flags = 4'h0; mem_ready = 1'b1;
    tick();
    @(negedge clk);
    check("reset_state", 32'(state), 32'd0);
    check("reset_wen", 32'({pc_write, ir_write, reg_write, mem_write, illegal}), 32'd0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("first_fetch_irw", 32'({ir_write, pc_write}), 32'b11);

    // Store stalled in MEMWRITE, then reset for two cycles aborts it.
    op = 7'h23; funct3 = 3'd2;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    @(negedge clk);
    check("memwrite_state", 32'(state), 32'd5);
    check("memwrite_we", 32'(mem_write), 32'd1);
    tick();
    rst = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    check("rst_memwrite_masked", 32'({state, mem_write}), 32'({4'd5, 1'b0}));
    tick();
    @(negedge clk);
    check("rst_cycle2", 32'({state, mem_write, ir_write, pc_write}), 32'({4'd0, 3'b000}));
    tick();
    rst = 1'b1;
    build_plan(K_STORE, 3'd2, 1'b0, 1'b0);
    run_plan(0, "after_rst_store");

    foreach (vecs[i]) begin
      op = vecs[i].op; funct3 = vecs[i].f3; funct7b5 = vecs[i].f7;
      flags = {1'b0, vecs[i].z, 2'b00}; mem_ready = 1'b1;
      cyc = 0; st3 = 4'hf; alu3 = 4'hf; pcw3 = 1'bx; ill2 = 1'bx;
      do begin
        @(negedge clk);
        cyc++;
        if (cyc == 2) ill2 = illegal;
        if (cyc == 3) begin st3 = state; alu3 = alu_control; pcw3 = pc_write; end
        tick();
      end while (state != 4'd0 && cyc < 20);
      if (cyc == 2) begin st3 = state; alu3 = alu_control; pcw3 = pc_write; end
      check($sformatf("vec%0d_len", i), 32'(cyc), 32'(vecs[i].len));
      check($sformatf("vec%0d_state3", i), 32'(st3), 32'(vecs[i].st3));
      check($sformatf("vec%0d_alu3", i), 32'(alu3), 32'(vecs[i].alu3));
      check($sformatf("vec%0d_pcw3", i), 32'(pcw3), 32'(vecs[i].pcw3));
      check($sformatf("vec%0d_illegal", i), 32'(ill2), 32'(vecs[i].ill2));
    end

    // Load with 3 stall cycles in FETCH and 2 in MEMREAD.
    op = 7'h03; funct3 = 3'd2; funct7b5 = 1'b0;
    cyc = 0; fz = 0; rz = 0; irp = 0; started = 0; rw4 = 1'b0; rs4 = 2'b11;
    do begin
      if (state == 4'd0 && fz < 3) begin mem_ready = 1'b0; fz++; end
      else if (state == 4'd3 && rz < 2) begin mem_ready = 1'b0; rz++; end
      else mem_ready = 1'b1;
      @(negedge clk);
      cyc++;
      irp += int'(ir_write);
      if (state == 4'd4) begin rw4 = reg_write; rs4 = result_src; end
      tick();
      if (state != 4'd0) started = 1;
    end while (!(state == 4'd0 && started) && cyc < 30);
    check("load_stall_cycles", 32'(cyc), 32'd10);
    check("load_stall_ir_pulses", 32'(irp), 32'd1);
    check("load_memwb_regw", 32'(rw4), 32'd1);
    check("load_memwb_src", 32'(rs4), 32'b01);

    // JALR state walk; pc_write only in JALR2 after fetch.
    op = 7'h67; funct3 = 3'd0; mem_ready = 1'b1;
    jst = '{4'd0, 4'd1, 4'd11, 4'd12, 4'd8};
    jpw = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("jalr_step%0d", i), 32'({state, pc_write}), 32'({jst[i], jpw[i]}));
      tick();
    end
    check("jalr_back_to_fetch", 32'(state), 32'd0);

    op = 7'h37; funct3 = 3'd5;
    tick(); tick();
    @(negedge clk);
    check("lui_outputs", 32'({state, alu_src_a, alu_src_b, alu_control}),
          32'({4'd13, 2'b11, 2'b01, 4'b0000}));
    tick(); tick();

    // Illegal decodes: one-cycle pulse, no writes, straight back to FETCH.
    for (int i = 0; i < 2; i++) begin
      op = (i == 0) ? 7'h7f : 7'h63; funct3 = (i == 0) ? 3'd0 : 3'd2;
      tick();
      @(negedge clk);
      check($sformatf("illegal%0d_decode", i),
            32'({state, illegal, pc_write, ir_write, reg_write, mem_write}),
            32'({4'd1, 1'b1, 4'b0000}));
      tick();
      @(negedge clk);
      check($sformatf("illegal%0d_next", i), 32'({state, illegal}), 32'({4'd0, 1'b0}));
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("illegal_masked_in_reset", 32'({state, illegal}), 32'({4'd1, 1'b0}));
    tick();
    rst = 1'b1;
    check("illegal_reset_to_fetch", 32'(state), 32'd0);

    for (int n = 0; n < 150; n++) begin
      op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 10)];
      funct3 = 3'($urandom_range(0, 7));
      funct7b5 = 1'($urandom_range(0, 1));
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? a : $urandom;
      case (funct3[2:1])
        2'b00:   z = ((a - b) == 32'd0);
        2'b10:   z = !($signed(a) < $signed(b));
        2'b11:   z = !(a < b);
        default: z = 1'($urandom_range(0, 1));
      endcase
      case (funct3)
        3'd0:    taken = (a == b);
        3'd1:    taken = (a != b);
        3'd4:    taken = ($signed(a) < $signed(b));
        3'd5:    taken = !($signed(a) < $signed(b));
        3'd6:    taken = (a < b);
        3'd7:    taken = !(a < b);
        default: taken = 1'b0;
      endcase
      flags = {1'($urandom_range(0, 1)), z, 2'($urandom_range(0, 3))};
      k = classify(op, funct3);
      build_plan(k, funct3, funct7b5, taken);
      run_plan(3, $sformatf("rand%0d_op%0h", n, op));
    end
    @(negedge clk);
    check("final_fetch", 32'(state), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
